ahb_i2c_slave_if: RTL

- AHB-Lite slave that consumes the transfers driven by the team's AHB master (haddr/htrans/hsize/hburst/hwrite/hwdata).
- Decodes a small register map and buffers TX/RX bytes in two FIFOs.
- Presents a command/byte handshake to the downstream I2C byte engine.
- This is the AHB side of the AHB-to-I2C bridge.

---
 rtl/ahb_i2c_slave_if.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_i2c_slave_if.sv
// AHB-Lite slave front end of the AHB-to-I2C bridge: register map, TX/RX byte
// FIFOs and the command handshake toward the I2C byte engine.
module ahb_i2c_slave_if #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [6:0]  cmd_addr,
  output logic [7:0]  cmd_len,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        i2c_busy,
  input  logic        i2c_nack
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_SADDR  = 3'd2;
  localparam logic [2:0] OFF_TXDATA = 3'd3;
  localparam logic [2:0] OFF_RXDATA = 3'd4;

  typedef enum logic [1:0] {PH_IDLE, PH_DATA, PH_ERR2} phase_t;

  phase_t phase, phase_nxt;
  logic [2:0] dp_addr;
  logic       dp_write;
  logic [2:0] dp_size;

  logic       ctrl_rw;
  logic [7:0] ctrl_len;
  logic [6:0] saddr;
  logic       nack, rx_ovf;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;

  logic busy, tx_full, tx_empty, rx_full, rx_empty;
  logic err_now, ok_dp, sample;
  logic wr_ctrl, wr_status, wr_saddr, wr_txdata, rd_rxdata;
  logic tx_push, tx_pop, rx_push, rx_pop, ovf_set, launch;
  logic [31:0] status_word;
  logic unused_sig;

  assign unused_sig = ^{haddr[31:5], haddr[1:0], htrans[0], hburst, hwdata[31:16]};

  assign busy     = cmd_valid | i2c_busy;
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_valid = ~tx_empty;
  assign tx_byte  = tx_mem[tx_rd_ptr];

  assign status_word = {8'h00, 8'(rx_count), 8'(tx_count), 1'b0, rx_ovf, nack,
                        rx_empty, rx_full, tx_empty, tx_full, busy};

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      phase    <= PH_IDLE;
      dp_addr  <= '0;
      dp_write <= 1'b0;
      dp_size  <= '0;
    end else begin
      phase <= phase_nxt;
      if (sample) begin
        dp_addr  <= haddr[4:2];
        dp_write <= hwrite;
        dp_size  <= hsize;
      end
    end
  end

  // Errors are detected in the data phase itself, so the first error cycle
  // stalls combinationally and side effects are gated by ok_dp.
  always_comb begin
    err_now   = 1'b0;
    hrdata    = '0;
    wr_ctrl   = 1'b0;
    wr_status = 1'b0;
    wr_saddr  = 1'b0;
    wr_txdata = 1'b0;
    rd_rxdata = 1'b0;
    if (phase == PH_DATA) begin
      err_now = (dp_size != 3'b010) || (dp_addr > OFF_RXDATA) ||
                (dp_write && dp_addr == OFF_TXDATA && tx_full) ||
                (!dp_write && dp_addr == OFF_RXDATA && rx_empty) ||
                (dp_write && dp_addr == OFF_CTRL && hwdata[0] && busy);
    end
    ok_dp  = (phase == PH_DATA) && !err_now;
    hready = ~err_now;
    hresp  = err_now || (phase == PH_ERR2);
    sample = hsel && htrans[1] && hready;

    if (sample)       phase_nxt = PH_DATA;
    else if (err_now) phase_nxt = PH_ERR2;
    else              phase_nxt = PH_IDLE;

    if (ok_dp) begin
      if (dp_write) begin
        wr_ctrl   = (dp_addr == OFF_CTRL);
        wr_status = (dp_addr == OFF_STATUS);
        wr_saddr  = (dp_addr == OFF_SADDR);
        wr_txdata = (dp_addr == OFF_TXDATA);
      end else begin
        rd_rxdata = (dp_addr == OFF_RXDATA);
        case (dp_addr)
          OFF_CTRL:   hrdata = {16'h0000, ctrl_len, 6'b0, ctrl_rw, 1'b0};
          OFF_STATUS: hrdata = status_word;
          OFF_SADDR:  hrdata = {25'h0, saddr};
          OFF_RXDATA: hrdata = {24'h0, rx_mem[rx_rd_ptr]};
          default:    hrdata = '0;
        endcase
      end
    end
  end

  assign launch  = wr_ctrl && hwdata[0] && (hwdata[15:8] != 8'h00);
  assign tx_push = wr_txdata;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_pop  = rd_rxdata;
  // A full RX FIFO still accepts a push when a pop frees the slot this cycle.
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign ovf_set = rx_valid & rx_full & ~rx_pop;

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      ctrl_rw   <= 1'b0;
      ctrl_len  <= '0;
      saddr     <= '0;
      cmd_valid <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      nack      <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_rw  <= hwdata[1];
        ctrl_len <= hwdata[15:8];
      end
      if (wr_saddr) saddr <= hwdata[6:0];
      if (launch) begin
        cmd_valid <= 1'b1;
        cmd_rw    <= hwdata[1];
        cmd_addr  <= saddr;
        cmd_len   <= hwdata[15:8];
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      nack   <= i2c_nack | (nack   & ~(wr_status & hwdata[5]));
      rx_ovf <= ovf_set  | (rx_ovf & ~(wr_status & hwdata[6]));
    end
  end

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge Hclk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= hwdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_byte;
  end

endmodule
